// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program store and sequencer for the control unit.
// Holds a loadable program memory, a program counter and a run/halt FSM.
// It emits one registered 10-bit iiiidddddd word per cycle, plus a valid flag.
// Reserved opcodes: 4'b1101 is NOP (the bubble word) and 4'b1110 is HALT.
// Program memory is not cleared by reset_global. Its contents come from the
// loading interface, and a loaded program survives any reset.
module instr_fetch_unit #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset_global,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [9:0]        prog_data,
    input  logic              run,
    input  logic              stall,
    input  logic              load,
    input  logic [7:0]        set_value,
    output logic [9:0]        instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [15:0]       instr_count
);

    localparam logic [9:0] NOP_WORD = 10'h340;
    localparam logic [3:0] HALT_OP  = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_next;
    logic [9:0]        instruction_next;
    logic              instr_valid_next;
    logic              halted_next;
    logic [15:0]       instr_count_next;
    logic              mem_we;
    logic [9:0]        fetch_word;
    logic [9:0]        mem [DEPTH];

    // Only the low address bits of the jump target are meaningful.
    logic set_value_unused;
    assign set_value_unused = ^set_value[7:ADDR_W];

    assign fetch_word = mem[pc];

    // Program memory: written only while not running, never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_global) begin
            state       <= S_IDLE;
            pc          <= '0;
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            instr_count <= 16'd0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instruction <= instruction_next;
            instr_valid <= instr_valid_next;
            halted      <= halted_next;
            instr_count <= instr_count_next;
        end
    end

    // Next-state logic: load beats stall, and a fetched HALT word stops the PC.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instruction_next = instruction;
        instr_valid_next = instr_valid;
        halted_next      = 1'b0;
        instr_count_next = instr_count;
        mem_we           = 1'b0;

        unique case (state)
            S_IDLE, S_HALT: begin
                mem_we = prog_we;
                // In HALT, halted lags state entry by a cycle so the HALT
                // word itself is seen with halted still low.
                if (state == S_HALT) begin
                    instruction_next = NOP_WORD;
                    instr_valid_next = 1'b0;
                    halted_next      = 1'b1;
                end
                if (run) begin
                    state_next       = S_RUN;
                    pc_next          = '0;
                    instr_count_next = 16'd0;
                    instruction_next = NOP_WORD;
                    instr_valid_next = 1'b0;
                    halted_next      = 1'b0;
                end
            end
            S_RUN: begin
                if (load) begin
                    pc_next          = set_value[ADDR_W-1:0];
                    instruction_next = NOP_WORD;
                    instr_valid_next = 1'b0;
                end else if (!stall) begin
                    instruction_next = fetch_word;
                    instr_valid_next = 1'b1;
                    if (instr_count != 16'hFFFF) begin
                        instr_count_next = instr_count + 16'd1;
                    end
                    if (fetch_word[9:6] == HALT_OP) begin
                        state_next = S_HALT;
                    end else begin
                        pc_next = pc + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vectors with hand-computed expectations.
module tb_instr_fetch_unit;

    logic       clk;
    logic       reset_global;
    logic       prog_we;
    logic [5:0] prog_addr;
    logic [9:0] prog_data;
    logic       run;
    logic       stall;
    logic       load;
    logic [7:0] set_value;
    logic [9:0] instruction;
    logic       instr_valid;
    logic [5:0] pc;
    logic       halted;
    logic [15:0] instr_count;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit #(.ADDR_W(6), .DEPTH(64)) dut (
        .clk          (clk),
        .reset_global (reset_global),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .run          (run),
        .stall        (stall),
        .load         (load),
        .set_value    (set_value),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Check every output after the current edge.
    task automatic checkAll(input string tag, input logic [9:0] e_instr,
                            input logic e_valid, input logic [5:0] e_pc,
                            input logic e_halted, input logic [15:0] e_count);
        checkOutput({tag, ".instruction"}, 32'(instruction), 32'(e_instr));
        checkOutput({tag, ".instr_valid"}, 32'(instr_valid), 32'(e_valid));
        checkOutput({tag, ".pc"},          32'(pc),          32'(e_pc));
        checkOutput({tag, ".halted"},      32'(halted),      32'(e_halted));
        checkOutput({tag, ".instr_count"}, 32'(instr_count), 32'(e_count));
    endtask

    // Drive one cycle of inputs, then wait one edge plus settle time.
    task automatic applyStimulus(input logic rst, input logic we, input logic [5:0] addr,
                                 input logic [9:0] data, input logic r, input logic st,
                                 input logic ld, input logic [7:0] sv);
        reset_global = rst;
        prog_we      = we;
        prog_addr    = addr;
        prog_data    = data;
        run          = r;
        stall        = st;
        load         = ld;
        set_value    = sv;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 6'd0, 10'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic writeWord(input logic [5:0] addr, input logic [9:0] data);
        applyStimulus(1'b0, 1'b1, addr, data, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic runPulse();
        applyStimulus(1'b0, 1'b0, 6'd0, 10'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        // Reset for two cycles.
        applyStimulus(1'b1, 1'b0, 6'd0, 10'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0, 6'd0, 10'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        checkAll("reset", 10'h340, 1'b0, 6'd0, 1'b0, 16'd0);

        // Sequential fetch ending in HALT.
        writeWord(6'd0, 10'h00A);
        writeWord(6'd1, 10'h0D1);
        writeWord(6'd2, 10'h20B);
        writeWord(6'd3, 10'h380);
        runPulse();
        checkAll("seq.start", 10'h340, 1'b0, 6'd0, 1'b0, 16'd0);
        idleCycle(); checkAll("seq.w0", 10'h00A, 1'b1, 6'd1, 1'b0, 16'd1);
        idleCycle(); checkAll("seq.w1", 10'h0D1, 1'b1, 6'd2, 1'b0, 16'd2);
        idleCycle(); checkAll("seq.w2", 10'h20B, 1'b1, 6'd3, 1'b0, 16'd3);
        idleCycle(); checkAll("seq.halt_word", 10'h380, 1'b1, 6'd3, 1'b0, 16'd4);
        idleCycle(); checkAll("seq.halted", 10'h340, 1'b0, 6'd3, 1'b1, 16'd4);
        // load ignored while halted.
        applyStimulus(1'b0, 1'b0, 6'd0, 10'd0, 1'b0, 1'b0, 1'b1, 8'h15);
        checkAll("seq.halt_load", 10'h340, 1'b0, 6'd3, 1'b1, 16'd4);

        // Jump with upper set_value bits ignored (8'hC5 -> 5).
        writeWord(6'd0, 10'h245);
        writeWord(6'd5, 10'h012);
        writeWord(6'd6, 10'h380);
        runPulse();
        checkAll("jmp.start", 10'h340, 1'b0, 6'd0, 1'b1 & 1'b0, 16'd0);
        idleCycle(); checkAll("jmp.w0", 10'h245, 1'b1, 6'd1, 1'b0, 16'd1);
        applyStimulus(1'b0, 1'b0, 6'd0, 10'd0, 1'b0, 1'b0, 1'b1, 8'hC5);
        checkAll("jmp.bubble", 10'h340, 1'b0, 6'd5, 1'b0, 16'd1);
        idleCycle(); checkAll("jmp.target", 10'h012, 1'b1, 6'd6, 1'b0, 16'd2);
        idleCycle(); checkAll("jmp.halt_word", 10'h380, 1'b1, 6'd6, 1'b0, 16'd3);
        idleCycle(); checkAll("jmp.halted", 10'h340, 1'b0, 6'd6, 1'b1, 16'd3);

        // Wrap-around; the jump also flushes the HALT word at address 0.
        writeWord(6'd63, 10'h001);
        writeWord(6'd0, 10'h380);
        runPulse();
        applyStimulus(1'b0, 1'b0, 6'd0, 10'd0, 1'b0, 1'b0, 1'b1, 8'h3F);
        checkAll("wrap.bubble", 10'h340, 1'b0, 6'd63, 1'b0, 16'd0);
        idleCycle(); checkAll("wrap.w63", 10'h001, 1'b1, 6'd0, 1'b0, 16'd1);
        idleCycle(); checkAll("wrap.halt_word", 10'h380, 1'b1, 6'd0, 1'b0, 16'd2);
        idleCycle(); checkAll("wrap.halted", 10'h340, 1'b0, 6'd0, 1'b1, 16'd2);

        // Stall holds everything; load together with stall is taken.
        writeWord(6'd0, 10'h011);
        writeWord(6'd1, 10'h022);
        writeWord(6'd2, 10'h033);
        writeWord(6'd7, 10'h077);
        writeWord(6'd8, 10'h380);
        runPulse();
        idleCycle(); checkAll("stall.w0", 10'h011, 1'b1, 6'd1, 1'b0, 16'd1);
        idleCycle(); checkAll("stall.w1", 10'h022, 1'b1, 6'd2, 1'b0, 16'd2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 6'd0, 10'd0, 1'b0, 1'b1, 1'b0, 8'd0);
            checkAll("stall.hold", 10'h022, 1'b1, 6'd2, 1'b0, 16'd2);
        end
        applyStimulus(1'b0, 1'b0, 6'd0, 10'd0, 1'b0, 1'b1, 1'b1, 8'h07);
        checkAll("stall.load", 10'h340, 1'b0, 6'd7, 1'b0, 16'd2);
        // Write attempt while running must not reach memory.
        applyStimulus(1'b0, 1'b1, 6'd8, 10'h055, 1'b0, 1'b0, 1'b0, 8'd0);
        checkAll("stall.w7", 10'h077, 1'b1, 6'd8, 1'b0, 16'd3);
        idleCycle(); checkAll("wprot.halt_word", 10'h380, 1'b1, 6'd8, 1'b0, 16'd4);
        idleCycle(); checkAll("wprot.halted", 10'h340, 1'b0, 6'd8, 1'b1, 16'd4);

        // Write in HALT, restart, then reset mid-run keeps the program.
        writeWord(6'd0, 10'h123);
        writeWord(6'd1, 10'h380);
        runPulse();
        checkAll("restart.start", 10'h340, 1'b0, 6'd0, 1'b0, 16'd0);
        idleCycle(); checkAll("restart.w0", 10'h123, 1'b1, 6'd1, 1'b0, 16'd1);
        applyStimulus(1'b1, 1'b0, 6'd0, 10'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        checkAll("midreset", 10'h340, 1'b0, 6'd0, 1'b0, 16'd0);
        // IDLE holds until run.
        idleCycle(); checkAll("idle.hold", 10'h340, 1'b0, 6'd0, 1'b0, 16'd0);
        runPulse();
        idleCycle(); checkAll("kept.w0", 10'h123, 1'b1, 6'd1, 1'b0, 16'd1);
        idleCycle(); checkAll("kept.halt_word", 10'h380, 1'b1, 6'd1, 1'b0, 16'd2);
        idleCycle(); checkAll("kept.halted", 10'h340, 1'b0, 6'd1, 1'b1, 16'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
